id_stage: RTL and testbench

- Instruction-decode stage, directly downstream of the fetch stage.
- Consumes the fetched instruction, pc and next_pc, and reads operands from an internal 32x32 register file that has one write-back port.
- Produces a registered ID/EX bundle: operands, fields, extended immediate and valid.
- Detects load-use hazards and requests a one-cycle fetch stall.

---
 rtl/id_stage.sv | 92 +++++++++
 tb/tb_id_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: instruction decode with 32x32 register file, load-use stall and registered ID/EX bundle.
// Optional same-cycle write-back bypass into operand reads: define ID_WB_BYPASS_EN.
module id_stage #(
    parameter int          RF_DEPTH = 32,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [31:0] ins_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic        flush,
    input  logic        stall,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        hazard_stall,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [5:0]  opcode_out,
    output logic [5:0]  funct_out,
    output logic [4:0]  shamt_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic [31:0] imm_out
);
    logic [31:0] rf [RF_DEPTH];
    logic [5:0]  opc;
    logic [4:0]  rs_idx, rt_idx;
    logic [31:0] rs_rd, rt_rd, rs_val, rt_val, imm;
    logic        is_load, kill;
    assign opc    = ins_in[31:26];
    assign rs_idx = ins_in[25:21];
    assign rt_idx = ins_in[20:16];
    assign rs_rd  = (rs_idx == 5'd0) ? '0 : rf[rs_idx];
    assign rt_rd  = (rt_idx == 5'd0) ? '0 : rf[rt_idx];
`ifdef ID_WB_BYPASS_EN
    assign rs_val = (wb_en && wb_addr != 5'd0 && wb_addr == rs_idx) ? wb_data : rs_rd;
    assign rt_val = (wb_en && wb_addr != 5'd0 && wb_addr == rt_idx) ? wb_data : rt_rd;
`else
    assign rs_val = rs_rd;
    assign rt_val = rt_rd;
`endif
    always_comb begin
        imm = (opc inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, ins_in[15:0]} :
              (opc == 6'h0F) ? {ins_in[15:0], 16'h0} : {{16{ins_in[15]}}, ins_in[15:0]};
    end
    assign is_load      = opcode_out inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    assign hazard_stall = !flush && valid_out && is_load && rt_out != 5'd0 &&
                          (rt_out == rs_idx || rt_out == rt_idx);
    assign kill         = flush | hazard_stall;
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        else if (wb_en && wb_addr != 5'd0)
            rf[wb_addr] <= wb_data;
    end
    // Flush and hazard bubbles both empty the slot; stall only holds when no flush.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            valid_out   <= 1'b0;
            pc_out      <= PC_RESET;
            next_pc_out <= PC_RESET;
            opcode_out  <= '0;
            funct_out   <= '0;
            shamt_out   <= '0;
            rs_out      <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            rs_data     <= '0;
            rt_data     <= '0;
            imm_out     <= '0;
        end else if (flush || !stall) begin
            valid_out   <= !kill;
            pc_out      <= kill ? PC_RESET : pc_in;
            next_pc_out <= kill ? PC_RESET : next_pc_in;
            opcode_out  <= kill ? '0 : opc;
            funct_out   <= kill ? '0 : ins_in[5:0];
            shamt_out   <= kill ? '0 : ins_in[10:6];
            rs_out      <= kill ? '0 : rs_idx;
            rt_out      <= kill ? '0 : rt_idx;
            rd_out      <= kill ? '0 : ins_in[15:11];
            rs_data     <= kill ? '0 : rs_val;
            rt_data     <= kill ? '0 : rt_val;
            imm_out     <= kill ? '0 : imm;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table, hand-written reset sequence, and randomized run against a reference model.
module tb_id_stage;
    logic        sys_clk = 1'b0, rst = 1'b1;
    logic [31:0] ins_in = '0, pc_in = '0, next_pc_in = '0, wb_data = '0;
    logic        flush = 1'b0, stall = 1'b0, wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        hazard_stall, valid_out;
    logic [31:0] pc_out, next_pc_out, rs_data, rt_data, imm_out;
    logic [5:0]  opcode_out, funct_out;
    logic [4:0]  shamt_out, rs_out, rt_out, rd_out;
    int tests = 0, fails = 0;

    id_stage dut (
        .sys_clk(sys_clk), .rst(rst), .ins_in(ins_in), .pc_in(pc_in), .next_pc_in(next_pc_in),
        .flush(flush), .stall(stall), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .valid_out(valid_out), .pc_out(pc_out), .next_pc_out(next_pc_out),
        .opcode_out(opcode_out), .funct_out(funct_out), .shamt_out(shamt_out), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .rs_data(rs_data), .rt_data(rt_data), .imm_out(imm_out)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    typedef struct {
        logic [31:0] ins, pc;
        logic        fl, st, we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        haz, v;
        logic [4:0]  rs, rt;
        logic [31:0] rsd, imm, pcx;
    } vec_t;
    vec_t tv[19];

`ifdef ID_WB_BYPASS_EN
    localparam logic [31:0] BYP = 32'hAA;
`else
    localparam logic [31:0] BYP = 32'h0;
`endif

    // reference model: architectural registers plus the instruction sitting in ID/EX
    typedef struct {
        logic        v;
        logic [31:0] pc, npc, ins, rsd, rtd;
    } slot_t;
    logic [31:0] regs [32];
    slot_t       m;

    function automatic logic [31:0] ext(input logic [31:0] ins);
        logic [5:0]  op  = ins[31:26];
        logic [15:0] i16 = ins[15:0];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) return {16'h0, i16};
        if (op == 6'h0F) return {i16, 16'h0};
        return {{16{i16[15]}}, i16};
    endfunction

    function automatic logic model_haz(input logic [31:0] ins, input logic fl);
        logic [5:0] op = m.ins[31:26];
        logic [4:0] rt = m.ins[20:16];
        logic       ld = op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
        return !fl && m.v && ld && rt != 0 && (rt == ins[25:21] || rt == ins[20:16]);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 0) return 0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return regs[a];
    endfunction

    task automatic check_slot(input string tag);
        chk({tag, " valid"}, 32'(valid_out), 32'(m.v));
        chk({tag, " pc"}, pc_out, m.pc);
        chk({tag, " npc"}, next_pc_out, m.npc);
        chk({tag, " opcode"}, 32'(opcode_out), 32'(m.ins[31:26]));
        chk({tag, " funct"}, 32'(funct_out), 32'(m.ins[5:0]));
        chk({tag, " shamt"}, 32'(shamt_out), 32'(m.ins[10:6]));
        chk({tag, " rs"}, 32'(rs_out), 32'(m.ins[25:21]));
        chk({tag, " rt"}, 32'(rt_out), 32'(m.ins[20:16]));
        chk({tag, " rd"}, 32'(rd_out), 32'(m.ins[15:11]));
        chk({tag, " rs_data"}, rs_data, m.rsd);
        chk({tag, " rt_data"}, rt_data, m.rtd);
        chk({tag, " imm"}, imm_out, ext(m.ins));
    endtask

    initial begin
        logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2B};
        logic [31:0] ins;
        logic        haz;
        slot_t       nx;
        //            ins           pc        fl st we wa  wd            haz v  rs rt rsd           imm           pcx
        tv[0]  = '{32'h00000000, 32'h1000, 0, 0, 1, 8, 32'h12345678, 0, 1, 0, 0, 32'h0,        32'h0,        32'h1000};
        tv[1]  = '{32'h2109FFFF, 32'h1004, 0, 0, 0, 0, 32'h0,        0, 1, 8, 9, 32'h12345678, 32'hFFFFFFFF, 32'h1004};
        tv[2]  = '{32'h35098000, 32'h1008, 0, 0, 0, 0, 32'h0,        0, 1, 8, 9, 32'h12345678, 32'h00008000, 32'h1008};
        tv[3]  = '{32'h3C091234, 32'h100C, 0, 0, 0, 0, 32'h0,        0, 1, 0, 9, 32'h0,        32'h12340000, 32'h100C};
        tv[4]  = '{32'h8D090000, 32'h1010, 0, 0, 0, 0, 32'h0,        0, 1, 8, 9, 32'h12345678, 32'h0,        32'h1010};
        tv[5]  = '{32'h01295020, 32'h1014, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        32'h0};
        tv[6]  = '{32'h01295020, 32'h1018, 0, 0, 0, 0, 32'h0,        0, 1, 9, 9, 32'h0,        32'h00005020, 32'h1018};
        tv[7]  = '{32'h2109FFFF, 32'h101C, 0, 1, 0, 0, 32'h0,        0, 1, 9, 9, 32'h0,        32'h00005020, 32'h1018};
        tv[8]  = '{32'h2109FFFF, 32'h1020, 0, 1, 0, 0, 32'h0,        0, 1, 9, 9, 32'h0,        32'h00005020, 32'h1018};
        tv[9]  = '{32'h2109FFFF, 32'h1024, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0};
        tv[10] = '{32'h20000001, 32'h1028, 0, 0, 1, 0, 32'hDEAD,     0, 1, 0, 0, 32'h0,        32'h1,        32'h1028};
        tv[11] = '{32'h20000002, 32'h102C, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 32'h0,        32'h2,        32'h102C};
        tv[12] = '{32'h20A60000, 32'h1030, 0, 0, 1, 5, 32'hAA,       0, 1, 5, 6, BYP,          32'h0,        32'h1030};
        tv[13] = '{32'h20A60000, 32'h1034, 0, 0, 0, 0, 32'h0,        0, 1, 5, 6, 32'hAA,       32'h0,        32'h1034};
        tv[14] = '{32'h8CA70000, 32'h1038, 0, 0, 0, 0, 32'h0,        0, 1, 5, 7, 32'hAA,       32'h0,        32'h1038};
        tv[15] = '{32'h00070820, 32'h103C, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0};
        tv[16] = '{32'h8CA70000, 32'h1040, 0, 0, 0, 0, 32'h0,        0, 1, 5, 7, 32'hAA,       32'h0,        32'h1040};
        tv[17] = '{32'h00070820, 32'h1044, 0, 0, 0, 0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0,        32'h0};
        tv[18] = '{32'h00070820, 32'h1048, 0, 0, 0, 0, 32'h0,        0, 1, 0, 7, 32'h0,        32'h00000820, 32'h1048};

        #12 rst = 1'b0;
        chk("reset valid", 32'(valid_out), 0);
        chk("reset pc", pc_out, 0);
        chk("reset rs_data", rs_data, 0);
        @(posedge sys_clk); #1;
        for (int i = 0; i < 19; i++) begin
            ins_in = tv[i].ins; pc_in = tv[i].pc; next_pc_in = tv[i].pc + 4;
            flush = tv[i].fl; stall = tv[i].st; wb_en = tv[i].we; wb_addr = tv[i].wa; wb_data = tv[i].wd;
            #1 chk($sformatf("vec%0d hazard", i), 32'(hazard_stall), 32'(tv[i].haz));
            @(posedge sys_clk); #1;
            chk($sformatf("vec%0d valid", i), 32'(valid_out), 32'(tv[i].v));
            chk($sformatf("vec%0d rs", i), 32'(rs_out), 32'(tv[i].rs));
            chk($sformatf("vec%0d rt", i), 32'(rt_out), 32'(tv[i].rt));
            chk($sformatf("vec%0d rs_data", i), rs_data, tv[i].rsd);
            chk($sformatf("vec%0d imm", i), imm_out, tv[i].imm);
            chk($sformatf("vec%0d pc", i), pc_out, tv[i].pcx);
        end
        flush = 0; stall = 0; wb_en = 0;

        // asynchronous reset in the middle of a load-use stall
        ins_in = 32'h8CA70000;
        @(posedge sys_clk); #1;
        ins_in = 32'h00070820;
        #1 chk("pre-reset hazard", 32'(hazard_stall), 1);
        #2 rst = 1'b1;
        #1;
        chk("async reset valid", 32'(valid_out), 0);
        chk("async reset hazard", 32'(hazard_stall), 0);
        chk("async reset rs_out", 32'(rs_out), 0);
        chk("async reset rs_data", rs_data, 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        ins_in = 32'h20A60000;
        @(posedge sys_clk); #1;
        chk("rf cleared r5", rs_data, 0);
        chk("post-reset valid", 32'(valid_out), 1);

        rst = 1'b1;
        @(posedge sys_clk); #1;
        rst = 1'b0;
        foreach (regs[i]) regs[i] = '0;
        m = '{v: 0, pc: 0, npc: 0, ins: 0, rsd: 0, rtd: 0};
        check_slot("rand reset");
        for (int c = 0; c < 2000; c++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 11)];
            ins[25:21] = 5'($urandom_range(0, 7));
            ins[20:16] = 5'($urandom_range(0, 7));
            ins_in = ins; pc_in = $urandom; next_pc_in = pc_in + 4;
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 7) == 0);
            wb_en = $urandom_range(0, 1);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            #1;
            haz = model_haz(ins, flush);
            chk("rand hazard", 32'(hazard_stall), 32'(haz));
            nx = m;
            if (flush || (!stall && haz)) nx = '{v: 0, pc: 0, npc: 0, ins: 0, rsd: 0, rtd: 0};
            else if (!stall) nx = '{v: 1, pc: pc_in, npc: next_pc_in, ins: ins,
                                   rsd: model_rd(ins[25:21]), rtd: model_rd(ins[20:16])};
            if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
            @(posedge sys_clk); #1;
            m = nx;
            check_slot("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
